// File: rtl/fb_op_sequencer.sv
// Row-operation engine for the baby-VGA framebuffer: clear, fill, scroll up/down.
// Shares the framebuffer write port with direct CPU writes, which always win.
module fb_op_sequencer #(
   parameter int ROWS   = 16,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic              cmd_sync,
   input  logic [WIDTH-1:0]  cmd_data,
   input  logic              abort,
   input  logic              vblank,
   input  logic              cpu_wr_en,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [WIDTH-1:0]  cpu_wr_data,
   output logic              fb_wr_en,
   output logic [ADDR_W-1:0] fb_wr_addr,
   output logic [WIDTH-1:0]  fb_wr_data,
   output logic [ADDR_W-1:0] fb_rd_addr,
   input  logic [WIDTH-1:0]  fb_rd_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {IDLE, WAIT_VB, READ, WRITE, FINAL, DONE} state_t;

   localparam logic [1:0]        OP_CLEAR = 2'b00;
   localparam logic [1:0]        OP_DOWN  = 2'b11;
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
   localparam logic [ADDR_W-1:0] PENULT   = ADDR_W'(ROWS - 2);

   state_t              state, state_nxt;
   logic [1:0]          op_q;
   logic [WIDTH-1:0]    data_q;
   logic [ADDR_W-1:0]   row;
   logic [WIDTH-1:0]    rd_hold;
   logic                have_rd;
   logic                accept;
   logic                seq_wr;
   logic                seq_go;
   logic [WIDTH-1:0]    seq_data;

   assign accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Scroll ends on a row compare (penultimate row up, row 1 down); the
   // following +/-1 step lands exactly on the row FINAL must write.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (cmd_sync && !vblank) state_nxt = WAIT_VB;
               else                     state_nxt = cmd_op[1] ? READ : FINAL;
            end
         end
         WAIT_VB: begin
            if (abort)       state_nxt = IDLE;
            else if (vblank) state_nxt = op_q[1] ? READ : FINAL;
         end
         READ: state_nxt = abort ? IDLE : WRITE;
         WRITE: begin
            if (abort) state_nxt = IDLE;
            else if (seq_go)
               state_nxt = (row == ((op_q == OP_DOWN) ? ONE : PENULT)) ? FINAL : READ;
         end
         FINAL: begin
            if (abort) state_nxt = IDLE;
            else if (seq_go && (op_q[1] || row == LAST_ROW)) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A stalled WRITE keeps the first-returned read data, since the read
   // port no longer points at the source row once READ is left.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q    <= '0;
         data_q  <= '0;
         row     <= '0;
         rd_hold <= '0;
         have_rd <= 1'b0;
      end else begin
         if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            row    <= (cmd_op == OP_DOWN) ? LAST_ROW : '0;
         end else if (seq_go) begin
            row <= (state == WRITE && op_q == OP_DOWN) ? row - ONE : row + ONE;
         end
         if (state == WRITE && state_nxt == WRITE) begin
            if (!have_rd) begin
               rd_hold <= fb_rd_data;
               have_rd <= 1'b1;
            end
         end else begin
            have_rd <= 1'b0;
         end
      end
   end

   always_comb begin
      cmd_ready  = (state == IDLE) && !abort;
      busy       = (state != IDLE) && (state != DONE);
      done       = (state == DONE);
      fb_rd_addr = '0;
      if (state == READ) fb_rd_addr = (op_q == OP_DOWN) ? row - ONE : row + ONE;
      seq_wr   = ((state == WRITE) || (state == FINAL)) && !abort;
      seq_go   = seq_wr && !cpu_wr_en;
      seq_data = '0;
      if (state == WRITE)        seq_data = have_rd ? rd_hold : fb_rd_data;
      else if (op_q != OP_CLEAR) seq_data = data_q;
      fb_wr_en   = cpu_wr_en || seq_wr;
      fb_wr_addr = '0;
      fb_wr_data = '0;
      if (cpu_wr_en) begin
         fb_wr_addr = cpu_wr_addr;
         fb_wr_data = cpu_wr_data;
      end else if (seq_wr) begin
         fb_wr_addr = row;
         fb_wr_data = seq_data;
      end
   end

endmodule

// File: tb/tb_fb_op_sequencer.sv
// Self-checking bench for fb_op_sequencer: a slot-queue reference model predicts
// every cycle's outputs and the final framebuffer contents.
module tb_fb_op_sequencer;

   logic        clk, rst_n, cmd_valid, cmd_ready, cmd_sync, abort, vblank;
   logic        cpu_wr_en, fb_wr_en, busy, done;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_data, cpu_wr_data, fb_wr_data, fb_rd_data;
   logic [3:0]  cpu_wr_addr, fb_wr_addr, fb_rd_addr;

   fb_op_sequencer #(.ROWS(16), .WIDTH(32), .ADDR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_sync(cmd_sync), .cmd_data(cmd_data), .abort(abort),
      .vblank(vblank), .cpu_wr_en(cpu_wr_en), .cpu_wr_addr(cpu_wr_addr),
      .cpu_wr_data(cpu_wr_data), .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
      .fb_wr_data(fb_wr_data), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Framebuffer: synchronous read-before-write.
   logic [31:0] fbmem [16];
   always @(posedge clk) begin
      fb_rd_data <= fbmem[fb_rd_addr];
      if (fb_wr_en) fbmem[fb_wr_addr] <= fb_wr_data;
   end

   typedef struct {
      bit          is_read;
      bit          from_rd;
      logic [3:0]  addr;
      logic [31:0] data;
   } slot_t;

   // Model phases: 0 idle, 1 waiting for vblank, 2 running slots, 3 done pulse.
   int          m_phase;
   slot_t       q[$];
   logic [31:0] m_held;
   logic [31:0] mmem [16];

   int vectors, miscompares;
   int cyc, done_cyc, first_wr, seq_writes, accepts;
   bit busy_log [400];

   task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic pushSlot(input bit rd, input bit fr, input int addr, input logic [31:0] data);
      slot_t s;
      s.is_read = rd;
      s.from_rd = fr;
      s.addr    = 4'(addr);
      s.data    = data;
      q.push_back(s);
   endtask

   task automatic buildQueue(input logic [1:0] op, input logic [31:0] data);
      q.delete();
      case (op)
         2'b00, 2'b01: for (int r = 0; r < 16; r++) pushSlot(0, 0, r, (op == 2'b00) ? 32'h0 : data);
         2'b10: begin
            for (int d = 0; d < 15; d++) begin
               pushSlot(1, 0, d + 1, 32'h0);
               pushSlot(0, 1, d, 32'h0);
            end
            pushSlot(0, 0, 15, data);
         end
         default: begin
            for (int d = 15; d >= 1; d--) begin
               pushSlot(1, 0, d - 1, 32'h0);
               pushSlot(0, 1, d, 32'h0);
            end
            pushSlot(0, 0, 0, data);
         end
      endcase
   endtask

   task automatic checkOutput();
      bit seq_w;
      seq_w = (m_phase == 2) && (q.size() > 0) && !q[0].is_read && !abort;
      compareValue("cmd_ready", 32'(cmd_ready), 32'((m_phase == 0) && !abort));
      compareValue("busy", 32'(busy), 32'((m_phase == 1) || (m_phase == 2)));
      compareValue("done", 32'(done), 32'(m_phase == 3));
      compareValue("fb_wr_en", 32'(fb_wr_en), 32'(cpu_wr_en || seq_w));
      if (cpu_wr_en) begin
         compareValue("cpu_wr_addr", 32'(fb_wr_addr), 32'(cpu_wr_addr));
         compareValue("cpu_wr_data", fb_wr_data, cpu_wr_data);
      end else if (seq_w) begin
         compareValue("seq_wr_addr", 32'(fb_wr_addr), 32'(q[0].addr));
         compareValue("seq_wr_data", fb_wr_data, q[0].from_rd ? m_held : q[0].data);
      end
      if (m_phase == 2 && q.size() > 0 && q[0].is_read)
         compareValue("fb_rd_addr", 32'(fb_rd_addr), 32'(q[0].addr));
      if (cyc >= 0 && cyc < 400) busy_log[cyc] = busy;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (fb_wr_en && !cpu_wr_en) begin
         seq_writes++;
         if (first_wr < 0) first_wr = cyc;
      end
   endtask

   task automatic modelAdvance();
      bit          seq_w;
      logic [31:0] rdv;
      rdv   = 32'h0;
      seq_w = (m_phase == 2) && (q.size() > 0) && !q[0].is_read && !abort;
      if (m_phase == 2 && q.size() > 0 && q[0].is_read) rdv = mmem[q[0].addr];
      if (seq_w && !cpu_wr_en) mmem[q[0].addr] = q[0].from_rd ? m_held : q[0].data;
      if (cpu_wr_en) mmem[cpu_wr_addr] = cpu_wr_data;
      if (!rst_n) begin
         m_phase = 0;
         q.delete();
      end else begin
         case (m_phase)
            0: if (cmd_valid && !abort) begin
                  buildQueue(cmd_op, cmd_data);
                  accepts++;
                  m_phase = (cmd_sync && !vblank) ? 1 : 2;
               end
            1: if (abort) m_phase = 0;
               else if (vblank) m_phase = 2;
            2: if (abort) begin
                  m_phase = 0;
                  q.delete();
               end else if (q[0].is_read) begin
                  m_held = rdv;
                  void'(q.pop_front());
               end else if (!cpu_wr_en) begin
                  void'(q.pop_front());
                  if (q.size() == 0) m_phase = 3;
               end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      checkOutput();
      modelAdvance();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input bit rnd);
      cyc = -1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      rst_n     = 1'b1;
      for (int r = 0; r < 16; r++) begin
         cpu_wr_en   = 1'b1;
         cpu_wr_addr = 4'(r);
         cpu_wr_data = rnd ? $urandom : 32'(r) * 32'h01010101;
         applyStimulus();
      end
      cpu_wr_en = 1'b0;
   endtask

   task automatic runOp(input logic [1:0] op, input bit sync, input logic [31:0] data,
                        input int vb_delay, input int cpu_from, input int cpu_len,
                        input logic [3:0] c_addr, input logic [31:0] c_data,
                        input int cpu_pct, input int abort_at, input int rst_at);
      int acc0;
      int k;
      bit valid;
      acc0 = accepts;
      done_cyc = -1;
      first_wr = -1;
      seq_writes = 0;
      cmd_op = op;
      cmd_sync = sync;
      cmd_data = data;
      for (k = 0; k < 400; k++) begin
         valid = (accepts == acc0) || (abort_at >= 0 && k >= abort_at && accepts - acc0 < 2);
         if (k > 0 && m_phase == 0 && !valid && k > abort_at + 2 && k > rst_at + 2) break;
         cyc       = k;
         cmd_valid = valid;
         abort     = (abort_at >= 0) && (k == abort_at || k == abort_at + 1);
         vblank    = (vb_delay < 0) || (k > vb_delay);
         rst_n     = (k != rst_at);
         if (k >= cpu_from && k < cpu_from + cpu_len) begin
            cpu_wr_en   = 1'b1;
            cpu_wr_addr = c_addr;
            cpu_wr_data = c_data;
         end else if (cpu_pct > 0 && $urandom_range(99) < cpu_pct) begin
            cpu_wr_en   = 1'b1;
            cpu_wr_addr = 4'($urandom_range(15));
            cpu_wr_data = $urandom;
         end else begin
            cpu_wr_en = 1'b0;
         end
         applyStimulus();
      end
      if (k >= 400) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL timeout: observed no return to idle, expected within 400 cycles");
      end
      cmd_valid = 1'b0;
      abort     = 1'b0;
      cpu_wr_en = 1'b0;
      rst_n     = 1'b1;
      for (int r = 0; r < 16; r++)
         compareValue($sformatf("row%0d", r), fbmem[r], mmem[r]);
   endtask

   initial begin
      vectors = 0; miscompares = 0; accepts = 0; m_phase = 0; m_held = 32'h0;
      cyc = -1; done_cyc = -1; first_wr = -1; seq_writes = 0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_sync = 1'b0; cmd_data = 32'h0;
      abort = 1'b0; vblank = 1'b0; cpu_wr_en = 1'b0; cpu_wr_addr = 4'h0; cpu_wr_data = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus();
      compareValue("reset_rd_addr", 32'(fb_rd_addr), 32'h0);
      rst_n = 1'b1;

      $display("[TB] clear, no sync");
      preload(0);
      runOp(2'b00, 0, 32'h0, -1, -1, 0, 4'h0, 32'h0, 0, -1, -1);
      compareValue("clear_done_cycle", 32'(done_cyc), 32'd17);
      compareValue("clear_writes", 32'(seq_writes), 32'd16);
      compareValue("clear_row7", fbmem[7], 32'h0);

      $display("[TB] scroll up");
      preload(0);
      runOp(2'b10, 0, 32'hDEADBEEF, -1, -1, 0, 4'h0, 32'h0, 0, -1, -1);
      compareValue("up_done_cycle", 32'(done_cyc), 32'd32);
      compareValue("up_row0", fbmem[0], 32'h01010101);
      compareValue("up_row14", fbmem[14], 32'h0F0F0F0F);
      compareValue("up_row15", fbmem[15], 32'hDEADBEEF);

      $display("[TB] scroll down with CPU contention");
      preload(0);
      runOp(2'b11, 0, 32'hCAFEF00D, -1, 4, 3, 4'd3, 32'h12345678, 0, -1, -1);
      compareValue("down_done_cycle", 32'(done_cyc), 32'd35);
      compareValue("down_row0", fbmem[0], 32'hCAFEF00D);
      compareValue("down_row4", fbmem[4], 32'h12345678);
      compareValue("down_row15", fbmem[15], 32'h0E0E0E0E);

      $display("[TB] fill, synced to vblank");
      runOp(2'b01, 1, 32'hA5A5A5A5, 50, -1, 0, 4'h0, 32'h0, 0, -1, -1);
      compareValue("sync_first_write", 32'(first_wr), 32'd52);
      compareValue("sync_done_cycle", 32'(done_cyc), 32'd68);
      compareValue("sync_writes", 32'(seq_writes), 32'd16);

      $display("[TB] abort during scroll up");
      preload(0);
      runOp(2'b10, 0, 32'h5555AAAA, -1, -1, 0, 4'h0, 32'h0, 0, 5, -1);
      compareValue("abort_busy_c6", 32'(busy_log[6]), 32'h0);
      compareValue("abort_done_cycle", 32'(done_cyc), 32'd39);

      $display("[TB] reset during fill");
      runOp(2'b01, 0, 32'h3C3C3C3C, -1, -1, 0, 4'h0, 32'h0, 0, -1, 10);
      compareValue("rst_writes", 32'(seq_writes), 32'd10);
      compareValue("rst_no_done", 32'(done_cyc), 32'hFFFFFFFF);
      runOp(2'b01, 0, 32'h96969696, -1, -1, 0, 4'h0, 32'h0, 0, -1, -1);
      compareValue("post_rst_writes", 32'(seq_writes), 32'd16);
      compareValue("post_rst_done", 32'(done_cyc), 32'd17);

      $display("[TB] randomized commands");
      for (int n = 0; n < 16; n++) begin
         preload(1);
         runOp(2'($urandom_range(3)), 1'($urandom_range(1)), $urandom,
               int'($urandom_range(7)) - 1, -1, 0, 4'h0, 32'h0,
               int'($urandom_range(30)),
               ($urandom_range(4) == 0) ? int'($urandom_range(20, 1)) : -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
